date_to_doy_encoder: RTL
========================

Name: date_to_doy_encoder

Overview:
- Inverse of the month/day calculator. Takes a calendar date as month plus two BCD day digits and produces the day-of-year, both as a binary value and as three BCD digits for the dual seven-seg drivers.
- Used for date entry. The result can be fed back through the month/day path, or checked against it, on the same board clock.
- Multi-cycle: validates, accumulates month lengths one month per cycle, then does a serial binary-to-BCD conversion.

Parameters:
- LEAP, 0: when 1, February has 29 days and the maximum result is 366; when 0, February has 28 days and the maximum is 365.

Ports:
- clk  input  1  board clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- month  input  4  month number, 1-12.
- day1  input  4  day tens digit (BCD).
- day2  input  4  day ones digit (BCD).
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse when the result is ready.
- err  output  1  invalid date flag for the last request; valid while done is high and held afterwards.
- doy  output  9  binary day-of-year, 1-366; 0 when err is set.
- doy_hund  output  4  BCD hundreds digit of doy.
- doy_tens  output  4  BCD tens digit of doy.
- doy_ones  output  4  BCD ones digit of doy.

Behaviour:
- Reset, asynchronous: state goes to IDLE. busy, done, err, doy and all three BCD digits go to 0. Internal month, day, accumulator and shift registers are cleared.
- Reset mid-operation: the operation is aborted, no done pulse is produced, and all outputs show their reset values.
- IDLE: start=1 captures month, day1 and day2 into registers, then goes to CHECK. Inputs may change after the capture edge.
- start while busy: ignored. It is not queued.
- CHECK, 1 cycle:
  - Computes day = day1*10 + day2 in 5 bits.
  - The date is invalid if any of these hold:
    - month = 0 or month > 12
    - day1 > 3 or day2 > 9
    - day = 0
    - day > days_in_month(month)
  - days_in_month is 31/28(29 if LEAP)/31/30/31/30/31/31/30/31/30/31.
  - Invalid: set err=1, doy=0, all BCD digits=0, then go to DONE.
  - Valid: set acc=day, m=1, then go to ACCUM.
- ACCUM, one month per cycle:
  - If m < month: acc += days_in_month(m) and m increments.
  - If m == month: go to CONVERT with no add.
  - ACCUM therefore occupies exactly month cycles.
  - acc is 9 bits; it cannot overflow for valid input.
- CONVERT, exactly 9 cycles:
  - Shift-add-3 (double-dabble) of acc into a 12-bit BCD register.
  - Each cycle: add 3 to any BCD nibble that is 5 or more, then shift left one bit, bringing in the acc MSB.
- DONE, 1 cycle:
  - done=1.
  - doy, the BCD digits and err update at entry to DONE.
  - err=0 for a valid date.
  - Then return to IDLE.
- Outputs hold their last result until the next DONE or reset.
- Latency, taking the start-sample edge as cycle 0:
  - Valid date: done is high in cycle month+11, so 12 for January and 23 for December.
  - Invalid date: done is high in cycle 2.
- start held high through DONE: a new request is accepted in the first IDLE cycle after DONE. There is no back-to-back capture in the DONE cycle itself.

Test Plan:
- Minimum, LEAP=0: reset, then start with month=1, day1=0, day2=1. Required: busy rises the cycle after start; done pulses at cycle 12; doy=1, BCD 0/0/1, err=0.
- Maximum, LEAP=0: start with month=12, day1=3, day2=1. Required: done at cycle 23, doy=365, BCD 3/6/5.
- Invalid, LEAP=0: start with month=2, day1=2, day2=9. Required: done at cycle 2, err=1, doy=0, BCD 0/0/0. Also check month=13/day 01, month=4/day 31, month=5/day 00 and day2=10; each must give err=1.
- LEAP=1: 02/29 must give doy=60, BCD 0/6/0. 03/01 must give doy=61. 12/31 must give doy=366, BCD 3/6/6.
- Busy handling: start with 07/04 (doy 185), then pulse start with 01/01 at cycle 5. The second start must be ignored, a single done must follow at cycle 18, and doy must be 185.
- Reset mid-ACCUM: start with 10/15, then assert rst at cycle 6. Required: immediately busy=0 and all outputs 0, with no done pulse. A fresh 10/15 request must then complete at cycle 21 with doy=288.

Source files
------------

// File: rtl/date_to_doy_encoder.sv
// Date (month + BCD day) to day-of-year encoder.
// Validates the date, sums month lengths serially, then double-dabbles to BCD.
//
// Ports:
//   clk      : board clock, rising edge
//   rst      : asynchronous active-high reset
//   start    : request, sampled only while idle
//   month    : month number 1-12
//   day1     : day tens digit (BCD)
//   day2     : day ones digit (BCD)
//   busy     : high whenever not idle
//   done     : one-cycle result-ready pulse
//   err      : last request was an invalid date (held)
//   doy      : binary day-of-year, 0 on error
//   doy_hund : BCD hundreds digit of doy
//   doy_tens : BCD tens digit of doy
//   doy_ones : BCD ones digit of doy
module date_to_doy_encoder #(
  parameter int LEAP = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] month,
  input  logic [3:0] day1,
  input  logic [3:0] day2,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [8:0] doy,
  output logic [3:0] doy_hund,
  output logic [3:0] doy_tens,
  output logic [3:0] doy_ones
);

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    ACCUM,
    CONVERT,
    FIN
  } state_t;

  state_t state_q, state_d;

  logic [3:0]  month_q, month_d;
  logic [3:0]  d1_q, d1_d;
  logic [3:0]  d2_q, d2_d;
  logic [8:0]  acc_q, acc_d;
  logic [3:0]  m_q, m_d;
  logic [11:0] bcd_q, bcd_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        err_q, err_d;
  logic [8:0]  doy_q, doy_d;
  logic [3:0]  hund_q, hund_d;
  logic [3:0]  tens_q, tens_d;
  logic [3:0]  ones_q, ones_d;

  function automatic logic [4:0] dim_f(input logic [3:0] mm);
    logic [4:0] r;
    r = 5'd31;
    case (mm)
      4'd2:                     r = (LEAP != 0) ? 5'd29 : 5'd28;
      4'd4, 4'd6, 4'd9, 4'd11:  r = 5'd30;
      default:                  r = 5'd31;
    endcase
    return r;
  endfunction

  function automatic logic [3:0] adj3(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

  // Day computed wide so out-of-range digits cannot alias
  // into a small legal value.
  logic [7:0]  day_w;
  logic        invalid;
  logic [11:0] bcd_adj;
  logic [11:0] bcd_nx;
  logic [8:0]  acc_nx;

  assign day_w = ({4'b0, d1_q} * 8'd10) + {4'b0, d2_q};

  assign invalid = (month_q == 4'd0) || (month_q > 4'd12) ||
                   (d1_q > 4'd3) || (d2_q > 4'd9) ||
                   (day_w == 8'd0) ||
                   (day_w > {3'b0, dim_f(month_q)});

  assign bcd_adj = {adj3(bcd_q[11:8]), adj3(bcd_q[7:4]),
                    adj3(bcd_q[3:0])};
  assign bcd_nx  = {bcd_adj[10:0], acc_q[8]};
  // acc rotates rather than shifts: after nine steps it
  // holds the original binary value again.
  assign acc_nx  = {acc_q[7:0], acc_q[8]};

  always_comb begin
    state_d = state_q;
    month_d = month_q;
    d1_d    = d1_q;
    d2_d    = d2_q;
    acc_d   = acc_q;
    m_d     = m_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    doy_d   = doy_q;
    hund_d  = hund_q;
    tens_d  = tens_q;
    ones_d  = ones_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          month_d = month;
          d1_d    = day1;
          d2_d    = day2;
          state_d = CHECK;
        end
      end
      CHECK: begin
        if (invalid) begin
          err_d   = 1'b1;
          doy_d   = 9'd0;
          hund_d  = 4'd0;
          tens_d  = 4'd0;
          ones_d  = 4'd0;
          state_d = FIN;
        end else begin
          acc_d   = {1'b0, day_w};
          m_d     = 4'd1;
          bcd_d   = 12'd0;
          cnt_d   = 4'd0;
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        if (m_q < month_q) begin
          acc_d = acc_q + {4'b0, dim_f(m_q)};
          m_d   = m_q + 4'd1;
        end else begin
          state_d = CONVERT;
        end
      end
      CONVERT: begin
        bcd_d = bcd_nx;
        acc_d = acc_nx;
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd8) begin
          err_d   = 1'b0;
          doy_d   = acc_nx;
          hund_d  = bcd_nx[11:8];
          tens_d  = bcd_nx[7:4];
          ones_d  = bcd_nx[3:0];
          state_d = FIN;
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      month_q <= 4'd0;
      d1_q    <= 4'd0;
      d2_q    <= 4'd0;
      acc_q   <= 9'd0;
      m_q     <= 4'd0;
      bcd_q   <= 12'd0;
      cnt_q   <= 4'd0;
      err_q   <= 1'b0;
      doy_q   <= 9'd0;
      hund_q  <= 4'd0;
      tens_q  <= 4'd0;
      ones_q  <= 4'd0;
    end else begin
      state_q <= state_d;
      month_q <= month_d;
      d1_q    <= d1_d;
      d2_q    <= d2_d;
      acc_q   <= acc_d;
      m_q     <= m_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      doy_q   <= doy_d;
      hund_q  <= hund_d;
      tens_q  <= tens_d;
      ones_q  <= ones_d;
    end
  end

  assign busy     = (state_q != IDLE);
  assign done     = (state_q == FIN);
  assign err      = err_q;
  assign doy      = doy_q;
  assign doy_hund = hund_q;
  assign doy_tens = tens_q;
  assign doy_ones = ones_q;

endmodule
